// File: rtl/burst_pkg.sv
// Shared constants and the FIFO entry layout for the burst receive path.
// An entry carries one byte plus the flag marking it as the final byte of its burst.
package burst_pkg;

   localparam int BS_DATA_W    = 8;
   localparam int BS_DEPTH     = 32;
   localparam int BS_MAX_BURST = 16;
   localparam int BS_CNT_W     = 16;

   typedef struct packed {
      logic                 last;
      logic [BS_DATA_W-1:0] data;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/burst_sink_checker.sv
// Protocol properties of the burst_sink output side, kept apart from the datapath.
module burst_sink_checker #(
   parameter int DATA_W = 8
) (
   input logic              clk,
   input logic              reset_n,
   input logic              m_valid,
   input logic              m_ready,
   input logic [DATA_W-1:0] m_data,
   input logic              m_last,
   input logic              overflow,
   input logic [15:0]       burst_cnt
);

   a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

   a_overflow_sticky: assert property (@(posedge clk) disable iff (!reset_n)
      overflow |=> overflow);

   a_cnt_step: assert property (@(posedge clk) disable iff (!reset_n)
      1'b1 |=> ((burst_cnt == $past(burst_cnt)) || (burst_cnt == $past(burst_cnt) + 16'd1)));

endmodule

// File: rtl/burst_sink_fifo.sv
// Single-clock FIFO with occupancy count. A push is accepted when full
// only if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;
   logic             full_s;
   logic             empty_s;

   // Acceptance of push/pop from the current occupancy.
   always_comb begin
      full_s    = (count_r == CW'(DEPTH));
      empty_s   = (count_r == {CW{1'b0}});
      pop_ok_s  = pop & ~empty_s;
      push_ok_s = push & (~full_s | pop_ok_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign pop_data = mem_r[rd_ptr_r];
   assign count    = count_r;
   assign full     = full_s;
   assign empty    = empty_s;

endmodule

// File: rtl/burst_sink.sv
// Receive endpoint for the stack-reversal engine burst stream: stages each byte,
// tags the last byte of a burst, buffers it and re-emits it on valid/ready.
module burst_sink
   import burst_pkg::*;
#(
   parameter int DATA_W    = BS_DATA_W,
   parameter int DEPTH     = BS_DEPTH,
   parameter int MAX_BURST = BS_MAX_BURST
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              busy,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic [15:0]       burst_cnt,
   output logic              overflow
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              stg_v_r;
   logic [DATA_W-1:0] stg_d_r;
   logic              busy_r;
   logic              overflow_r;
   logic [15:0]       burst_cnt_r;

   entry_t            push_entry_s;
   entry_t            pop_entry_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic [CNT_W:0]    occupancy_s;
   logic              full_s;
   logic              empty_s;
   logic              pop_s;
   logic              last_s;
   logic              drop_s;
   logic              busy_next_s;

   // The end of a burst is only known when s_valid drops behind the staged byte.
   always_comb begin
      push_entry_s      = '{last: 1'b0, data: {DATA_W{1'b0}}};
      push_entry_s.last = ~s_valid;
      push_entry_s.data = stg_d_r;
      last_s            = stg_v_r & ~s_valid;
      pop_s             = ~empty_s & m_ready;
      drop_s            = stg_v_r & full_s & ~pop_s;
      occupancy_s       = {1'b0, fifo_count_s}
                        + {{CNT_W{1'b0}}, stg_v_r}
                        + {{CNT_W{1'b0}}, s_valid};
      if (occupancy_s > (CNT_W + 1)'(DEPTH - MAX_BURST)) begin
         busy_next_s = 1'b1;
      end else begin
         busy_next_s = 1'b0;
      end
   end

   // Stage register between the engine and the FIFO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stg_v_r <= 1'b0;
         stg_d_r <= {DATA_W{1'b0}};
      end else begin
         stg_v_r <= s_valid;
         stg_d_r <= s_data;
      end
   end

   // Flow-control and status registers; a dropped last byte still closes its burst.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_r      <= 1'b1;
         overflow_r  <= 1'b0;
         burst_cnt_r <= 16'd0;
      end else begin
         busy_r     <= busy_next_s;
         overflow_r <= overflow_r | drop_s;
         if (last_s) begin
            burst_cnt_r <= burst_cnt_r + 16'd1;
         end else begin
            burst_cnt_r <= burst_cnt_r;
         end
      end
   end

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (stg_v_r),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .pop_data  (pop_entry_s),
      .count     (fifo_count_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   assign busy      = busy_r;
   assign overflow  = overflow_r;
   assign burst_cnt = burst_cnt_r;
   assign m_valid   = ~empty_s;
   assign m_data    = pop_entry_s.data;
   assign m_last    = pop_entry_s.last;

endmodule
